// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: shadow EX/MEM/WB destinations, forwarding,
// load-use stalls and branch flush. Define HAZARD_STATS_EN to add stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned REG_W             = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic             id_rf_e,
  input  logic             id_load,
  input  logic             id_branch_taken,
  input  logic             mem_wait,
  output logic             pc_e,
  output logic             ifid_e,
  output logic             ifid_flush,
  output logic             nop_s,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
`ifdef HAZARD_STATS_EN
  output logic [1:0]       fwd_c,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`else
  output logic [1:0]       fwd_c
`endif
);

  typedef enum logic [0:0] {StRun, StStall} state_e;

  localparam logic [1:0]       StallInit = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [REG_W-1:0] RegPc     = '1;

  state_e           state_q;
  logic [1:0]       cnt_q;
  logic             ex_v_q, ex_rf_q, ex_ld_q;
  logic             mem_v_q, mem_rf_q, mem_ld_q;
  logic             wb_v_q, wb_rf_q;
  logic [REG_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic             load_use;

  // R15 is the PC and is never a forwarding or stall source.
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_W-1:0] src);
    if (!use_src || src == RegPc) return 2'b00;
    if (ex_v_q && ex_rf_q && ex_rd_q == src) return 2'b01;
    if (mem_v_q && mem_rf_q && mem_rd_q == src) return 2'b10;
    if (wb_v_q && wb_rf_q && wb_rd_q == src) return 2'b11;
    return 2'b00;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(id_use_rn, id_rn);
    fwd_b = fwd_sel(id_use_rm, id_rm);
    fwd_c = fwd_sel(id_use_rd, id_rd);
    // An EX-stage match is exactly the 01 select, since EX has top priority.
    load_use = ex_ld_q && (fwd_a == 2'b01 || fwd_b == 2'b01 || fwd_c == 2'b01);
  end

  always_comb begin
    pc_e       = 1'b1;
    ifid_e     = 1'b1;
    nop_s      = 1'b0;
    ifid_flush = 1'b0;
    if (!reset) begin
      pc_e = 1'b1;
    end else if (mem_wait) begin
      pc_e   = 1'b0;
      ifid_e = 1'b0;
    end else if (state_q == StStall || load_use) begin
      pc_e   = 1'b0;
      ifid_e = 1'b0;
      nop_s  = 1'b1;
    end else begin
      ifid_flush = id_branch_taken;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StRun;
      cnt_q    <= 2'd0;
      ex_v_q   <= 1'b0;
      ex_rd_q  <= '0;
      ex_rf_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_v_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_rf_q <= 1'b0;
      mem_ld_q <= 1'b0;
      wb_v_q   <= 1'b0;
      wb_rd_q  <= '0;
      wb_rf_q  <= 1'b0;
    end else if (!mem_wait) begin
      ex_v_q   <= !nop_s;
      ex_rd_q  <= id_rd;
      ex_rf_q  <= id_rf_e;
      ex_ld_q  <= id_load;
      mem_v_q  <= ex_v_q;
      mem_rd_q <= ex_rd_q;
      mem_rf_q <= ex_rf_q;
      mem_ld_q <= ex_ld_q;
      wb_v_q   <= mem_v_q;
      wb_rd_q  <= mem_rd_q;
      wb_rf_q  <= mem_rf_q;
      unique case (state_q)
        StRun: begin
          if (load_use && LOAD_STALL_CYCLES > 1) begin
            state_q <= StStall;
            cnt_q   <= StallInit;
          end
        end
        StStall: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_q <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (nop_s && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (ifid_flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (1 and 3 stall cycles) against a
// queue-of-instructions reference model, directed sequences then random traffic.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_rn, id_rm, id_rd;
  logic       id_use_rn, id_use_rm, id_use_rd, id_rf_e, id_load, id_branch_taken, mem_wait;

  logic       pc_e_a, ifid_e_a, fl_a, nop_a, pc_e_b, ifid_e_b, fl_b, nop_b;
  logic [1:0] fa_a, fb_a, fc_a, fa_b, fb_b, fc_b;
`ifdef HAZARD_STATS_EN
  logic [15:0] sc_a, fcn_a, sc_b, fcn_b;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .REG_W(4)) dut_a (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .id_rf_e(id_rf_e), .id_load(id_load), .id_branch_taken(id_branch_taken),
    .mem_wait(mem_wait), .pc_e(pc_e_a), .ifid_e(ifid_e_a), .ifid_flush(fl_a),
    .nop_s(nop_a), .fwd_a(fa_a), .fwd_b(fb_a),
`ifdef HAZARD_STATS_EN
    .fwd_c(fc_a), .stall_cnt(sc_a), .flush_cnt(fcn_a)
`else
    .fwd_c(fc_a)
`endif
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .REG_W(4)) dut_b (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .id_rf_e(id_rf_e), .id_load(id_load), .id_branch_taken(id_branch_taken),
    .mem_wait(mem_wait), .pc_e(pc_e_b), .ifid_e(ifid_e_b), .ifid_flush(fl_b),
    .nop_s(nop_b), .fwd_a(fa_b), .fwd_b(fb_b),
`ifdef HAZARD_STATS_EN
    .fwd_c(fc_b), .stall_cnt(sc_b), .flush_cnt(fcn_b)
`else
    .fwd_c(fc_b)
`endif
  );

  // Output vector: {pc_e, ifid_e, ifid_flush, nop_s, fwd_a, fwd_b, fwd_c}
  typedef struct packed {
    logic [9:0]  o_a;
    logic [9:0]  o_b;
    logic [15:0] s_a, f_a, s_b, f_b;
  } exp_t;

  typedef struct packed {
    logic       v;
    logic [3:0] rd;
    logic       rf;
    logic       ld;
  } ins_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: in-flight instructions [0]=EX [1]=MEM [2]=WB, plus bubbles still owed.
  ins_t pipe[2][3];
  int   left[2];
  int   scnt[2];
  int   fcnt[2];
  int   lsc[2] = '{1, 3};

  function automatic logic [1:0] model_fwd(input int m, input logic u, input logic [3:0] s);
    if (!u || s == 4'd15) return 2'b00;
    for (int k = 0; k < 3; k++)
      if (pipe[m][k].v && pipe[m][k].rf && pipe[m][k].rd == s) return 2'(k + 1);
    return 2'b00;
  endfunction

  task automatic step(input logic rst, input logic mw, input logic br,
                      input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                      input logic urn, input logic urm, input logic urd,
                      input logic rf, input logic ld);
    exp_t        e;
    logic [9:0]  o[2];
    logic [15:0] sc[2], fc[2];
    logic [1:0]  fa, fb, fcs;
    logic        haz, stall, pc, ie, fl, nop;
    @(posedge clk);
    #1;
    reset = rst; mem_wait = mw; id_branch_taken = br;
    id_rn = rn; id_rm = rm; id_rd = rd;
    id_use_rn = urn; id_use_rm = urm; id_use_rd = urd; id_rf_e = rf; id_load = ld;
    for (int m = 0; m < 2; m++) begin
      fa  = model_fwd(m, urn, rn);
      fb  = model_fwd(m, urm, rm);
      fcs = model_fwd(m, urd, rd);
      haz = left[m] == 0 && pipe[m][0].v && pipe[m][0].ld &&
            (fa == 2'b01 || fb == 2'b01 || fcs == 2'b01);
      stall = left[m] > 0 || haz;
      if (!rst) begin
        {pc, ie, fl, nop} = 4'b1100;
        fa = 2'b00; fb = 2'b00; fcs = 2'b00;
      end else if (mw) begin
        {pc, ie, fl, nop} = 4'b0000;
      end else if (stall) begin
        {pc, ie, fl, nop} = 4'b0001;
      end else begin
        {pc, ie, fl, nop} = {2'b11, br, 1'b0};
      end
      o[m]  = {pc, ie, fl, nop, fa, fb, fcs};
      sc[m] = rst ? 16'(scnt[m]) : 16'd0;
      fc[m] = rst ? 16'(fcnt[m]) : 16'd0;
      // Advance the model to the state after the coming edge.
      if (!rst) begin
        for (int k = 0; k < 3; k++) pipe[m][k] = '0;
        left[m] = 0; scnt[m] = 0; fcnt[m] = 0;
      end else begin
        if (fl && fcnt[m] < 65535) fcnt[m]++;
        if (nop && scnt[m] < 65535) scnt[m]++;
        if (!mw) begin
          pipe[m][2] = pipe[m][1];
          pipe[m][1] = pipe[m][0];
          pipe[m][0] = stall ? '0 : {1'b1, rd, rf, ld};
          if (haz) left[m] = lsc[m] - 1;
          else if (left[m] > 0) left[m]--;
        end
      end
    end
    e.o_a = o[0]; e.o_b = o[1];
    e.s_a = sc[0]; e.f_a = fc[0]; e.s_b = sc[1]; e.f_b = fc[1];
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_lsc1", 16'({pc_e_a, ifid_e_a, fl_a, nop_a, fa_a, fb_a, fc_a}), 16'(e.o_a));
      chk("out_lsc3", 16'({pc_e_b, ifid_e_b, fl_b, nop_b, fa_b, fb_b, fc_b}), 16'(e.o_b));
`ifdef HAZARD_STATS_EN
      chk("stall_cnt_lsc1", sc_a, e.s_a);
      chk("flush_cnt_lsc1", fcn_a, e.f_a);
      chk("stall_cnt_lsc3", sc_b, e.s_b);
      chk("flush_cnt_lsc3", fcn_b, e.f_b);
`endif
    end
  end

  function automatic logic [3:0] pick();
    int r = $urandom_range(0, 4);
    return r == 4 ? 4'd15 : 4'(r + 1);
  endfunction

  initial begin
    reset = 1'b0; mem_wait = 1'b0; id_branch_taken = 1'b0;
    id_rn = '0; id_rm = '0; id_rd = '0;
    id_use_rn = 0; id_use_rm = 0; id_use_rd = 0; id_rf_e = 0; id_load = 0;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 3; k++) pipe[m][k] = '0;
      left[m] = 0; scnt[m] = 0; fcnt[m] = 0;
    end
    // Reset state, with mem_wait and a branch present to show they are masked.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 2, 3, 1, 1, 1, 1, 1);
    // ADD r1,r2,r3 ; SUB r5,r1,r2 ; reader of r1
    step(1, 0, 0, 2, 3, 1, 1, 1, 0, 1, 0);
    step(1, 0, 0, 1, 2, 5, 1, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0, 6, 1, 0, 0, 1, 0);
    // LDR r3 ; ADD r5,r3,r1 held while stalled
    step(1, 0, 0, 4, 0, 3, 1, 0, 0, 1, 1);
    repeat (4) step(1, 0, 0, 3, 1, 5, 1, 1, 0, 1, 0);
    // Taken branch, no hazard
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // ADD r15 ; reader of r15
    step(1, 0, 0, 1, 2, 15, 1, 1, 0, 1, 0);
    step(1, 0, 0, 15, 15, 7, 1, 1, 0, 1, 0);
    // LDR r2 ; taken branch reading r2
    step(1, 0, 0, 4, 0, 2, 1, 0, 0, 1, 1);
    repeat (4) step(1, 0, 1, 2, 0, 0, 1, 0, 0, 0, 0);
    // LDR r3 ; ADD r3-dependent with a mem_wait in the middle of the stall
    step(1, 0, 0, 4, 0, 3, 1, 0, 0, 1, 1);
    step(1, 0, 0, 3, 1, 5, 1, 1, 0, 1, 0);
    step(1, 1, 0, 3, 1, 5, 1, 1, 0, 1, 0);
    step(1, 1, 1, 3, 1, 5, 1, 1, 0, 1, 0);
    repeat (4) step(1, 0, 0, 3, 1, 5, 1, 1, 0, 1, 0);
    // Store-data dependency on a load, then reset mid-stall
    step(1, 0, 0, 4, 0, 3, 1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 0, 3, 1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 3, 1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 3, 1, 0, 1, 0, 0);
    repeat (3) step(1, 0, 0, 1, 0, 3, 1, 0, 1, 0, 0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0)
        step($urandom_range(0, 49) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
             pick(), pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 3) != 0), $urandom_range(0, 2) == 0);
      else
        step($urandom_range(0, 49) != 0, $urandom_range(0, 9) == 0, id_branch_taken,
             id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd, id_rf_e, id_load);
    end
    for (int w = 0; w < 4 && sb.size() > 0; w++) @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage ARM-subset core (IF, ID, EX, MEM, WB).
- Keeps its own shadow of each in-flight instruction's destination register, RF write-enable and load flag.
- From that shadow it drives the PC enable, the IF/ID enable and flush, the NOP-select of the control-signal multiplexer, and three operand-forwarding selects.
- Sits beside the ControlUnit and the NOP multiplexer; it is the sole source of the pipeline's enable and select signals.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3).
- REG_W, 4, register-specifier width.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous reset, active-low
- id_rn  in  REG_W  ID first source
- id_rm  in  REG_W  ID second source
- id_rd  in  REG_W  ID destination; also the third source for stores
- id_use_rn  in  1  id_rn is read
- id_use_rm  in  1  id_rm is read
- id_use_rd  in  1  id_rd is read (store data)
- id_rf_e  in  1  ID instruction writes the register file
- id_load  in  1  ID instruction is a load
- id_branch_taken  in  1  B/BL resolved taken in ID
- mem_wait  in  1  data memory not ready; freeze the whole pipeline
- pc_e  out  1  PC register enable
- ifid_e  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID to NOP on next edge
- nop_s  out  1  1 = multiplexer passes all-zero control into EX
- fwd_a  out  2  forwarding select for rn
- fwd_b  out  2  forwarding select for rm
- fwd_c  out  2  forwarding select for store data
- Forward-select encoding: 00 register file, 01 EX result, 10 MEM result, 11 WB result.

Behaviour:
- Shadow state: each of EX, MEM and WB holds {valid, rd, rf_e, load}.
- Shadow advance on each posedge when not frozen:
  - EX takes the ID fields, or a bubble (valid=0) when nop_s=1.
  - MEM takes EX; WB takes MEM.
- Freeze: mem_wait=1 holds all shadow stages and the stall counter. Outputs in this cycle: pc_e=0, ifid_e=0, nop_s=0, ifid_flush=0.
- Reset (reset=0, async):
  - All shadow valid=0, stall counter=0, FSM=RUN.
  - Outputs: pc_e=1, ifid_e=1, ifid_flush=0, nop_s=0, fwd_*=00.
- Source match: a stage matches a source when that source is in use, the stage is valid with rf_e=1, rd equals the source, and the source is not 15. R15 is never forwarded or stalled on.
- Forwarding: combinational, priority EX > MEM > WB; no match gives 00.
- Load-use hazard: EX valid, load=1, and EX.rd matches any in-use ID source.
- FSM RUN (combinational outputs):
  - No hazard: pc_e=1, ifid_e=1, nop_s=0.
  - Hazard: pc_e=0, ifid_e=0, nop_s=1. If LOAD_STALL_CYCLES>1, load the counter with LOAD_STALL_CYCLES-1 and go to STALL at the edge.
- FSM STALL:
  - Outputs: pc_e=0, ifid_e=0, nop_s=1.
  - Counter decrements each unfrozen edge; return to RUN when it reaches 0.
  - Total bubbles per hazard = LOAD_STALL_CYCLES.
- While a stall is active, forwarding from the load's stage is still computed; consumers use it after the stall releases.
- Branch: id_branch_taken=1 in RUN with no hazard asserts ifid_flush=1 for exactly one cycle; pc_e stays 1.
- Branch during a hazard or in STALL is ignored: ifid_flush=0. ID re-presents the branch after the stall releases.
- Branch during mem_wait is ignored; it is re-evaluated once the freeze releases.
- Reset mid-stall aborts it: FSM=RUN, shadow cleared, no leftover bubbles.
- Pipeline latency: none added; all outputs act in the same cycle as the ID inputs.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - Each is a saturating counter (sticks at 16'hFFFF), reset to 0.
  - stall_cnt increments per unfrozen cycle with nop_s=1.
  - flush_cnt increments per cycle with ifid_flush=1.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- ADD r1,r2,r3 then SUB r5,r1,r2 back-to-back -> fwd_a=01 in SUB's ID cycle, no stall; next cycle an unrelated ID instruction reading r1 gets fwd_a=10.
- LDR r3 then ADD r5,r3,r1, LOAD_STALL_CYCLES=1 -> exactly one cycle of pc_e=0, ifid_e=0, nop_s=1; next cycle fwd_a=10; PC advances by 4 only after the bubble.
- Same sequence with LOAD_STALL_CYCLES=3 -> three consecutive bubble cycles; mem_wait=1 asserted mid-stall extends the stall by its length, with nop_s=0 during the freeze.
- Taken B with no hazard -> ifid_flush=1 for one cycle, pc_e=1. Taken B whose source depends on a load in EX -> ifid_flush=0 during the stall, then 1 in the following cycle.
- ADD r15 then an instruction reading r15 -> fwd_a=00, no stall. Assert reset=0 during a 3-cycle stall -> outputs immediately at reset values, no bubble after release.
- HAZARD_STATS_EN defined, 2 load-use hazards (LOAD_STALL_CYCLES=1) plus 1 taken branch -> stall_cnt=2, flush_cnt=1.
